// File: rtl/spi_output_pkg.sv
// Shared definitions for the SPI mode-0 master transmitter and the byte receiver it drives.
package spi_output_pkg;

  localparam int SPI_BYTE_W    = 8;
  localparam int SPI_BIT_CNT_W = $clog2(SPI_BYTE_W);

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_t;

  // True when the SCLK transition about to happen is the one on which data is sampled.
  function automatic logic is_sample_edge(input logic sclk_now);
    return (sclk_now == SPI_CPOL) ^ SPI_CPHA;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period timer: one-cycle tick every CLK_DIV system clocks, restartable on frame accept.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic i_sys_clk,
  input  logic i_sys_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst || i_clr) begin
      div_cnt <= '0;
    end else if (div_cnt == TERM) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign o_tick = (div_cnt == TERM);

endmodule

// File: rtl/spi_output.sv
// SPI mode-0 master: sends one MSB-first byte per SS-low frame of exactly 8 SCLK pulses
// and captures MISO into a parallel byte.
module spi_output
  import spi_output_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int SS_GAP  = 4
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic [SPI_BYTE_W-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_ready,
  output logic [SPI_BYTE_W-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_spi_clk,
  output logic                  o_spi_mosi,
  output logic                  o_spi_ss,
  input  logic                  i_spi_miso
);

  localparam int GAP_W = (SS_GAP > 1) ? $clog2(SS_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SS_GAP - 1);
  localparam logic [SPI_BIT_CNT_W-1:0] BIT_LAST = SPI_BIT_CNT_W'(SPI_BYTE_W - 1);

  spi_state_t state, state_next;

  // MSB goes straight onto MOSI at accept, so only the remaining bits are kept here.
  logic [SPI_BYTE_W-2:0]    tx_shift, tx_shift_next;
  logic [SPI_BYTE_W-1:0]    rx_shift, rx_shift_next;
  logic [SPI_BIT_CNT_W-1:0] bit_cnt, bit_cnt_next;
  logic [GAP_W-1:0]         gap_cnt, gap_cnt_next;
  logic                     spi_clk_next, spi_mosi_next, spi_ss_next;
  logic                     ready_next, rx_valid_next;
  logic [SPI_BYTE_W-1:0]    rx_data_next;
  logic                     tick;
  logic                     accept;

  assign accept = i_data_valid & o_ready;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .i_sys_clk(i_sys_clk),
    .i_sys_rst(i_sys_rst),
    .i_clr    (accept),
    .o_tick   (tick)
  );

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state      <= ST_IDLE;
      tx_shift   <= '0;
      rx_shift   <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      o_spi_clk  <= SPI_CPOL;
      o_spi_mosi <= 1'b0;
      o_spi_ss   <= 1'b1;
      o_ready    <= 1'b1;
      o_rx_valid <= 1'b0;
      o_rx_data  <= '0;
    end else begin
      state      <= state_next;
      tx_shift   <= tx_shift_next;
      rx_shift   <= rx_shift_next;
      bit_cnt    <= bit_cnt_next;
      gap_cnt    <= gap_cnt_next;
      o_spi_clk  <= spi_clk_next;
      o_spi_mosi <= spi_mosi_next;
      o_spi_ss   <= spi_ss_next;
      o_ready    <= ready_next;
      o_rx_valid <= rx_valid_next;
      o_rx_data  <= rx_data_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_SETUP;
      ST_SETUP: if (tick) state_next = ST_XFER;
      ST_XFER:  if (tick && !is_sample_edge(o_spi_clk) && (bit_cnt == BIT_LAST)) state_next = ST_HOLD;
      ST_HOLD:  if (tick) state_next = ST_GAP;
      ST_GAP:   if (gap_cnt == GAP_LAST) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_shift_next = tx_shift;
    rx_shift_next = rx_shift;
    bit_cnt_next  = bit_cnt;
    gap_cnt_next  = gap_cnt;
    spi_clk_next  = o_spi_clk;
    spi_mosi_next = o_spi_mosi;
    spi_ss_next   = o_spi_ss;
    ready_next    = o_ready;
    rx_valid_next = 1'b0;
    rx_data_next  = o_rx_data;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          tx_shift_next = i_data[SPI_BYTE_W-2:0];
          spi_mosi_next = i_data[SPI_BYTE_W-1];
          spi_ss_next   = 1'b0;
          ready_next    = 1'b0;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          spi_clk_next  = ~SPI_CPOL;
          rx_shift_next = {rx_shift[SPI_BYTE_W-2:0], i_spi_miso};
          bit_cnt_next  = '0;
        end
      end
      ST_XFER: begin
        if (tick) begin
          spi_clk_next = ~o_spi_clk;
          if (is_sample_edge(o_spi_clk)) begin
            rx_shift_next = {rx_shift[SPI_BYTE_W-2:0], i_spi_miso};
          end else if (bit_cnt != BIT_LAST) begin
            spi_mosi_next = tx_shift[SPI_BYTE_W-2];
            tx_shift_next = {tx_shift[SPI_BYTE_W-3:0], 1'b0};
            bit_cnt_next  = bit_cnt + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          spi_ss_next   = 1'b1;
          rx_data_next  = rx_shift;
          rx_valid_next = 1'b1;
          gap_cnt_next  = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          ready_next = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt + 1'b1;
        end
      end
      default: begin
        ready_next = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_output.sv
// Directed bench for spi_output: two instances (4/4 and 2/2 timing) with a behavioural
// slave/receiver model watching SCLK/MOSI/SS and serving MISO.
module tb_spi_output;

  localparam int A_DIV = 4;
  localparam int A_GAP = 4;
  localparam int B_DIV = 2;
  localparam int B_GAP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] a_data = 8'h00;
  logic       a_valid = 1'b0;
  logic       a_ready, a_rx_valid, a_sclk, a_mosi, a_ss;
  logic [7:0] a_rx_data;
  logic       a_miso = 1'b0;
  logic [7:0] a_slave_tx = 8'h3C;

  logic [7:0] b_data = 8'h00;
  logic       b_valid = 1'b0;
  logic       b_ready, b_rx_valid, b_sclk, b_mosi, b_ss, b_miso;
  logic [7:0] b_rx_data;

  spi_output #(.CLK_DIV(A_DIV), .SS_GAP(A_GAP)) dut_a (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_data(a_data), .i_data_valid(a_valid),
    .o_ready(a_ready), .o_rx_data(a_rx_data), .o_rx_valid(a_rx_valid),
    .o_spi_clk(a_sclk), .o_spi_mosi(a_mosi), .o_spi_ss(a_ss), .i_spi_miso(a_miso)
  );

  // Second instance loops MOSI back onto MISO, so it should capture what it sends.
  assign b_miso = b_mosi;

  spi_output #(.CLK_DIV(B_DIV), .SS_GAP(B_GAP)) dut_b (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_data(b_data), .i_data_valid(b_valid),
    .o_ready(b_ready), .o_rx_data(b_rx_data), .o_rx_valid(b_rx_valid),
    .o_spi_clk(b_sclk), .o_spi_mosi(b_mosi), .o_spi_ss(b_ss), .i_spi_miso(b_miso)
  );

  int a_acc_n = 0, a_acc_cyc = 0, a_acc_prev = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && a_valid && a_ready) begin
      a_acc_n    <= a_acc_n + 1;
      a_acc_prev <= a_acc_cyc;
      a_acc_cyc  <= cyc;
    end
  end

  logic       a_ss_q = 1'b1, a_sclk_q = 1'b0;
  int         a_len = 0, a_phase = 0, a_rise = 0, a_bitpos = 0, a_rx_cnt = 0;
  int         a_bad_phase = 0, a_ready_bad = 0, a_gap_len = 0, a_min_gap = 1000;
  int         a_frames = 0, a_last_len = 0, a_last_rise = 0;
  int         a_rxv_cnt = 0, a_rxv_cyc = 0, a_rx_n = 0;
  logic [7:0] a_shift = 8'h00, a_last_mosi = 8'h00, a_rxv_data = 8'h00;
  logic [7:0] a_rx_log [32];

  // Slave/receiver model for instance A; the receiver bit counter runs across frames.
  always @(negedge clk) begin
    if (rst) begin
      a_ss_q = 1'b1; a_sclk_q = 1'b0; a_rx_cnt = 0; a_bitpos = 0;
      a_miso = a_slave_tx[7];
    end else begin
      if (a_rx_valid) begin
        a_rxv_cnt++; a_rxv_cyc = cyc; a_rxv_data = a_rx_data;
      end
      if (!a_ss && a_ss_q) begin
        if (a_frames > 0 && a_gap_len < a_min_gap) a_min_gap = a_gap_len;
        a_len = 1; a_phase = 1; a_rise = 0; a_bitpos = 0;
        a_miso = a_slave_tx[7];
        if (a_ready) a_ready_bad++;
      end else if (!a_ss) begin
        a_len++;
        if (a_ready) a_ready_bad++;
        if (a_sclk != a_sclk_q) begin
          if (a_phase != A_DIV) a_bad_phase++;
          a_phase = 1;
          if (a_sclk) begin
            a_rise++;
            a_shift = {a_shift[6:0], a_mosi};
            a_rx_cnt++;
            if (a_rx_cnt == 8) begin
              if (a_rx_n < 32) a_rx_log[a_rx_n] = a_shift;
              a_rx_n++; a_rx_cnt = 0;
            end
          end else begin
            a_bitpos++;
            if (a_bitpos < 8) a_miso = a_slave_tx[7 - a_bitpos];
          end
        end else begin
          a_phase++;
        end
      end else if (!a_ss_q) begin
        if (a_phase != A_DIV) a_bad_phase++;
        a_last_len = a_len; a_last_rise = a_rise; a_last_mosi = a_shift;
        a_frames++; a_gap_len = 1;
      end else begin
        a_gap_len++;
      end
      a_ss_q = a_ss; a_sclk_q = a_sclk;
    end
  end

  logic       b_ss_q = 1'b1, b_sclk_q = 1'b0;
  int         b_len = 0, b_phase = 0, b_rise = 0, b_rx_cnt = 0, b_bad_phase = 0;
  int         b_frames = 0, b_last_len = 0, b_last_rise = 0, b_rxv_cnt = 0;
  logic [7:0] b_shift = 8'h00, b_last_mosi = 8'h00, b_last_rx = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      b_ss_q = 1'b1; b_sclk_q = 1'b0; b_rx_cnt = 0;
    end else begin
      if (b_rx_valid) b_rxv_cnt++;
      if (!b_ss && b_ss_q) begin
        b_len = 1; b_phase = 1; b_rise = 0;
      end else if (!b_ss) begin
        b_len++;
        if (b_sclk != b_sclk_q) begin
          if (b_phase != B_DIV) b_bad_phase++;
          b_phase = 1;
          if (b_sclk) begin
            b_rise++;
            b_shift = {b_shift[6:0], b_mosi};
            b_rx_cnt++;
            if (b_rx_cnt == 8) begin
              b_last_rx = b_shift; b_rx_cnt = 0;
            end
          end
        end else begin
          b_phase++;
        end
      end else if (!b_ss_q) begin
        if (b_phase != B_DIV) b_bad_phase++;
        b_last_len = b_len; b_last_rise = b_rise; b_last_mosi = b_shift;
        b_frames++;
      end
      b_ss_q = b_ss; b_sclk_q = b_sclk;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Presents one byte on instance A and returns on the negedge after it is accepted.
  task automatic applyStimulus(input logic [7:0] b);
    int i;
    a_data = b; a_valid = 1'b1; i = 0;
    while (!a_ready && i < 500) begin @(negedge clk); i++; end
    checkOutput("accept_wait", 32'(a_ready), 32'd1);
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic wait_frames_a(input int target);
    int i;
    i = 0;
    while (a_frames < target && i < 3000) begin @(negedge clk); i++; end
    checkOutput("frame_wait_a", 32'(a_frames >= target), 32'd1);
  endtask

  task automatic wait_sclk_rises_a(input int n);
    int i, r;
    logic p;
    i = 0; r = 0; p = a_sclk;
    while (r < n && i < 500) begin
      @(negedge clk);
      if (a_sclk && !p) r++;
      p = a_sclk; i++;
    end
    checkOutput("sclk_wait_a", 32'(r), 32'(n));
  endtask

  logic [7:0] seq [4] = '{8'h00, 8'hFF, 8'h81, 8'h5A};

  initial begin
    int f0, n0, rxv0, bad0, rb0, acc0, i;

    repeat (3) @(negedge clk);
    checkOutput("rst_ss", 32'(a_ss), 32'd1);
    checkOutput("rst_sclk", 32'(a_sclk), 32'd0);
    checkOutput("rst_mosi", 32'(a_mosi), 32'd0);
    checkOutput("rst_ready", 32'(a_ready), 32'd1);
    checkOutput("rst_rx_valid", 32'(a_rx_valid), 32'd0);
    checkOutput("rst_rx_data", 32'(a_rx_data), 32'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] single frame 0xA5, slave returns 0x3C");
    f0 = a_frames; n0 = a_rx_n; rxv0 = a_rxv_cnt; bad0 = a_bad_phase; rb0 = a_ready_bad;
    applyStimulus(8'hA5);
    wait_frames_a(f0 + 1);
    repeat (10) @(negedge clk);
    checkOutput("a5_mosi_bits", 32'(a_last_mosi), 32'hA5);
    checkOutput("a5_sclk_pulses", 32'(a_last_rise), 32'd8);
    checkOutput("a5_ss_low_len", 32'(a_last_len), 32'd68);
    checkOutput("a5_phase_errs", 32'(a_bad_phase - bad0), 32'd0);
    checkOutput("a5_ready_in_frame", 32'(a_ready_bad - rb0), 32'd0);
    checkOutput("a5_rx_count", 32'(a_rx_n - n0), 32'd1);
    checkOutput("a5_receiver_byte", 32'(a_rx_log[n0]), 32'hA5);
    checkOutput("miso_rx_valid_pulses", 32'(a_rxv_cnt - rxv0), 32'd1);
    checkOutput("miso_rx_data_at_valid", 32'(a_rxv_data), 32'h3C);
    checkOutput("miso_rx_data_out", 32'(a_rx_data), 32'h3C);
    checkOutput("miso_latency", 32'(a_rxv_cyc - a_acc_cyc), 32'd69);

    $display("[TB] back-to-back 00 FF 81 5A");
    f0 = a_frames; n0 = a_rx_n;
    a_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_data = seq[k]; i = 0;
      while (!a_ready && i < 500) begin @(negedge clk); i++; end
      checkOutput("b2b_accept", 32'(a_ready), 32'd1);
      @(negedge clk);
    end
    a_valid = 1'b0;
    wait_frames_a(f0 + 4);
    repeat (5) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("b2b_byte%0d", k), 32'(a_rx_log[n0 + k]), 32'(seq[k]));
    end
    checkOutput("b2b_min_ss_gap", 32'(a_min_gap), 32'(A_GAP + 1));
    checkOutput("b2b_accept_interval", 32'(a_acc_cyc - a_acc_prev), 32'(1 + 17 * A_DIV + A_GAP));

    $display("[TB] reset during SCLK pulse 4");
    f0 = a_frames; rxv0 = a_rxv_cnt;
    applyStimulus(8'h77);
    wait_sclk_rises_a(4);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ss", 32'(a_ss), 32'd1);
    checkOutput("midrst_sclk", 32'(a_sclk), 32'd0);
    checkOutput("midrst_mosi", 32'(a_mosi), 32'd0);
    checkOutput("midrst_ready", 32'(a_ready), 32'd1);
    checkOutput("midrst_rx_valid", 32'(a_rx_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst_no_rx_valid", 32'(a_rxv_cnt - rxv0), 32'd0);
    checkOutput("midrst_no_frame_end", 32'(a_frames - f0), 32'd0);
    f0 = a_frames; n0 = a_rx_n;
    applyStimulus(8'hC3);
    wait_frames_a(f0 + 1);
    repeat (3) @(negedge clk);
    checkOutput("c3_mosi_bits", 32'(a_last_mosi), 32'hC3);
    checkOutput("c3_sclk_pulses", 32'(a_last_rise), 32'd8);
    checkOutput("c3_ss_low_len", 32'(a_last_len), 32'd68);
    checkOutput("c3_receiver_byte", 32'(a_rx_log[n0]), 32'hC3);

    $display("[TB] valid pulses outside IDLE");
    f0 = a_frames; acc0 = a_acc_n;
    applyStimulus(8'h11);
    a_data = 8'hEE; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    wait_sclk_rises_a(3);
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    i = 0;
    while (!a_ss && i < 500) begin @(negedge clk); i++; end
    checkOutput("gap_reached", 32'(a_ss), 32'd1);
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("ignore_accepts", 32'(a_acc_n - acc0), 32'd1);
    checkOutput("ignore_frames", 32'(a_frames - f0), 32'd1);
    checkOutput("ignore_mosi_bits", 32'(a_last_mosi), 32'h11);

    $display("[TB] CLK_DIV=2 SS_GAP=2 instance, 0x96");
    f0 = b_frames; rxv0 = b_rxv_cnt;
    b_data = 8'h96; b_valid = 1'b1; i = 0;
    while (!b_ready && i < 500) begin @(negedge clk); i++; end
    checkOutput("b_accept_wait", 32'(b_ready), 32'd1);
    @(negedge clk);
    b_valid = 1'b0;
    i = 0;
    while (b_frames == f0 && i < 1000) begin @(negedge clk); i++; end
    repeat (5) @(negedge clk);
    checkOutput("b_frame_done", 32'(b_frames - f0), 32'd1);
    checkOutput("b_ss_low_len", 32'(b_last_len), 32'd34);
    checkOutput("b_sclk_pulses", 32'(b_last_rise), 32'd8);
    checkOutput("b_phase_errs", 32'(b_bad_phase), 32'd0);
    checkOutput("b_mosi_bits", 32'(b_last_mosi), 32'h96);
    checkOutput("b_receiver_byte", 32'(b_last_rx), 32'h96);
    checkOutput("b_loop_rx_data", 32'(b_rx_data), 32'h96);
    checkOutput("b_rx_valid_pulses", 32'(b_rxv_cnt - rxv0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
